// File: rtl/flag_branch_unit_pkg.sv
// Shared constants for the flag/branch unit: opcodes,
// branch condition codes and flag bit positions.
package flag_branch_unit_pkg;

  localparam int FB_OPW = 4;

  localparam logic [3:0] OP_ADD    = 4'b0000;
  localparam logic [3:0] OP_SUB    = 4'b0001;
  localparam logic [3:0] OP_XOR    = 4'b0010;
  localparam logic [3:0] OP_RED    = 4'b0011;
  localparam logic [3:0] OP_SLL    = 4'b0100;
  localparam logic [3:0] OP_SRA    = 4'b0101;
  localparam logic [3:0] OP_ROR    = 4'b0110;
  localparam logic [3:0] OP_PADDSB = 4'b0111;
  localparam logic [3:0] OP_LW     = 4'b1000;
  localparam logic [3:0] OP_SW     = 4'b1001;
  localparam logic [3:0] OP_LLB    = 4'b1010;
  localparam logic [3:0] OP_LHB    = 4'b1011;
  localparam logic [3:0] OP_B      = 4'b1100;
  localparam logic [3:0] OP_BR     = 4'b1101;
  localparam logic [3:0] OP_PCS    = 4'b1110;
  localparam logic [3:0] OP_HLT    = 4'b1111;

  localparam logic [2:0] CC_NE  = 3'b000;
  localparam logic [2:0] CC_EQ  = 3'b001;
  localparam logic [2:0] CC_GT  = 3'b010;
  localparam logic [2:0] CC_LT  = 3'b011;
  localparam logic [2:0] CC_GTE = 3'b100;
  localparam logic [2:0] CC_LTE = 3'b101;
  localparam logic [2:0] CC_OV  = 3'b110;
  localparam logic [2:0] CC_UN  = 3'b111;

  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

endpackage

// File: rtl/flag_branch_unit_cond.sv
// branch_cond_eval: combinational condition check.
// Ports: Cond (3b code), Flags {Z,V,N} -> Branch_Taken.
module branch_cond_eval
  import flag_branch_unit_pkg::*;
(
  input  logic [2:0] Cond,
  input  logic [2:0] Flags,
  output logic       Branch_Taken
);

  logic z, v, n;

  assign z = Flags[FLAG_Z];
  assign v = Flags[FLAG_V];
  assign n = Flags[FLAG_N];

  always_comb begin
    Branch_Taken = 1'b0;
    unique case (Cond)
      CC_NE:  Branch_Taken = ~z;
      CC_EQ:  Branch_Taken = z;
      CC_GT:  Branch_Taken = ~z & ~n;
      CC_LT:  Branch_Taken = n;
      CC_GTE: Branch_Taken = z | (~z & ~n);
      CC_LTE: Branch_Taken = n | z;
      CC_OV:  Branch_Taken = v;
      CC_UN:  Branch_Taken = 1'b1;
    endcase
  end

endmodule

// File: rtl/flag_branch_unit.sv
// Z/V/N flag register with per-opcode write masks plus
// branch decision. Ports: clk, rst_n, En, Halt, Opcode,
// Result, Ovfl, Cond -> Flags {Z,V,N}, Branch_Taken.
module flag_branch_unit
  import flag_branch_unit_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             En,
  input  logic             Halt,
  input  logic [OPW-1:0]   Opcode,
  input  logic [WIDTH-1:0] Result,
  input  logic             Ovfl,
  input  logic [2:0]       Cond,
  output logic [2:0]       Flags,
  output logic             Branch_Taken
);

  logic       upd;
  logic       wr_all;
  logic       wr_z;
  logic       zero;
  logic [3:0] op;
  logic [2:0] flags_q;

  assign op   = 4'(Opcode);
  assign upd  = En & ~Halt;
  assign zero = (Result == '0);

  always_comb begin
    wr_all = 1'b0;
    wr_z   = 1'b0;
    unique case (1'b1)
      (op == OP_ADD) || (op == OP_SUB):
        wr_all = 1'b1;
      (op == OP_XOR) || (op == OP_SLL) ||
      (op == OP_SRA) || (op == OP_ROR):
        wr_z = 1'b1;
      default: ;
    endcase
  end

  // Gate checked first so an undriven opcode/result
  // on an idle cycle can never reach the register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= 3'b000;
    end else if (upd) begin
      if (wr_all) begin
        flags_q[FLAG_Z] <= zero;
        flags_q[FLAG_V] <= Ovfl;
        flags_q[FLAG_N] <= Result[WIDTH-1];
      end else if (wr_z) begin
        flags_q[FLAG_Z] <= zero;
      end
    end
  end

  assign Flags = flags_q;

  branch_cond_eval u_cond (
    .Cond         (Cond),
    .Flags        (flags_q),
    .Branch_Taken (Branch_Taken)
  );

endmodule

// File: doc/flag_branch_unit.md
Name: flag_branch_unit

Overview:
- Sits directly downstream of the execute-stage shifter/ALU result mux in the single-cycle core.
- Consumes the 16-bit execute result, the adder overflow indication and the current opcode, and holds the architectural Z/V/N flag register.
- Evaluates the 3-bit branch condition code against the held flags and produces the branch-taken decision for the PC logic.
- Flag updates are sequential, one per instruction; branch evaluation is combinational on the registered flags.

Parameters:
- WIDTH, 16, datapath width of Result.
- OPW, 4, opcode width.

Ports:
- clk  input  1  core clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- En  input  1  instruction in execute is valid and committing this cycle.
- Halt  input  1  processor halted; freezes all flag state.
- Opcode  input  OPW  opcode of the committing instruction.
- Result  input  WIDTH  execute result (ALU or shifter output, already saturated for ADD/SUB).
- Ovfl  input  1  adder signed-overflow indication for ADD/SUB this cycle.
- Cond  input  3  branch condition field of B/BR instruction.
- Flags  output  3  registered flags {Z,V,N}.
- Branch_Taken  output  1  condition satisfied by the current registered flags.

Behaviour:
- Reset: async assert of rst_n drives Flags=3'b000 immediately.
  - Branch_Taken then follows combinationally from zero flags: 1 for Cond 000, 010, 100 and 111; 0 otherwise.
  - Deassertion takes effect at the next rising edge.
- Update gating: a flag write occurs at a rising edge only when En=1, Halt=0 and rst_n=1. Otherwise all three flags hold.
- Per-opcode update masks:
  - ADD 0000, SUB 0001: Z=(Result==0), V=Ovfl, N=Result[15]; all three written.
  - XOR 0010, SLL 0100, SRA 0101, ROR 0110: only Z written, Z=(Result==0); V and N hold.
  - All other opcodes (RED, PADDSB, LW, SW, LLB, LHB, B, BR, PCS, HLT): no flag change.
- Ovfl is ignored for every opcode except ADD/SUB.
- Branch evaluation is purely combinational from the registered Flags and Cond, with zero-cycle latency:
  - 000 NE: Z==0.
  - 001 EQ: Z==1.
  - 010 GT: Z==0 and N==0.
  - 011 LT: N==1.
  - 100 GTE: Z==1 or (Z==0 and N==0).
  - 101 LTE: N==1 or Z==1.
  - 110 OV: V==1.
  - 111 UN: always 1.
- Ordering: a branch sees flags produced by earlier instructions only. A flag-writing instruction's own result is visible to Branch_Taken starting the cycle after its commit edge.
- Halt dominates En when both are 1 in the same cycle: no update.
- Reset mid-operation: an in-flight update is discarded and Flags read 000 until the next committed flag-writing instruction.
- X on Opcode or Result while En=0 or Halt=1 must not corrupt Flags.

Decomposition:
- Shared package holds:
  - opcode localparams (OP_ADD..OP_HLT);
  - condition-code localparams (CC_NE..CC_UN);
  - flag bit indices (FLAG_Z=2, FLAG_V=1, FLAG_N=0).
- One natural sub-module: branch_cond_eval, combinational, inputs Cond and Flags, output Branch_Taken.
- The flag register and update-mask decode stay in flag_branch_unit.

Test Plan:
1. Reset: rst_n=0 asynchronously mid-cycle -> Flags=000 without waiting for a clock edge; Cond=111 -> Branch_Taken=1; Cond=001 -> Branch_Taken=0.
2. ADD result 16'h0000 with Ovfl=0, En=1 -> after edge Flags=100 (Z=1); Cond=001 -> Branch_Taken=1.
3. SUB result 16'h8000 with Ovfl=1, En=1 -> Flags=011; Cond=110 -> 1, Cond=011 -> 1, Cond=010 -> 0.
4. Flags=011, then SRA result 16'h0000 -> Flags=111 (only Z changes); then SLL result 16'h0001 -> Flags=011.
5. Flags=100, then LW/RED/PADDSB with Result=0x1234, and separately ADD with En=0 or Halt=1 -> Flags remains 100 each cycle.
6. Sweep all 8 Cond values against all 8 Flag patterns (64 cases) -> Branch_Taken matches the condition table, each checked in the same cycle.
